// File: rtl/spinn_aer_if_cmd_demux_pkg.sv
// SpiNNaker-link packet layout shared by the AER interface command demux.
// Pure definitions, no logic and no latency.
// No flow control here; users apply their own handshakes.
package spinn_aer_if_cmd_demux_pkg;

    localparam int PKT_BITS   = 72;
    localparam int PAR_BIT    = 0;
    localparam int LONG_BIT   = 1;
    localparam int TYPE_LSB   = 6;
    localparam int TYPE_MSB   = 7;
    localparam int KEY_LSB    = 8;
    localparam int KEY_MSB    = 39;
    localparam int KEY_BITS   = KEY_MSB - KEY_LSB + 1;
    localparam int SHORT_BITS = 40;

    typedef enum logic [1:0] {
        PKT_MC  = 2'b00,
        PKT_P2P = 2'b01,
        PKT_NN  = 2'b10,
        PKT_FR  = 2'b11
    } pkt_type_e;

    typedef struct packed {
        logic par_ok;
        logic ctl;
    } pkt_class_t;

    // Odd parity over the header and key, plus the payload only for long packets.
    function automatic logic odd_parity_ok(input logic [PKT_BITS-1:0] pkt);
        logic x;
        if (pkt[LONG_BIT]) begin
            x = ^pkt;
        end else begin
            x = ^pkt[SHORT_BITS-1:0];
        end
        return x;
    endfunction

endpackage

// File: rtl/spinn_aer_if_pkt_reg.sv
// Single-slot valid/ready register with pass-through refill; can also discard its content.
// Latency: one cycle from accept to out_vld.
// Backpressure: in_rdy = !full || leaving, so a draining slot reloads in the same cycle.
module spinn_aer_if_pkt_reg #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_data,
    output logic         out_vld,
    input  logic         out_rdy,
    input  logic         drop
);

    logic         full;
    logic [W-1:0] data;
    logic         leave;

    // The slot empties when its content is consumed downstream or discarded.
    assign leave    = full && (out_rdy || drop);
    assign in_rdy   = !full || leave;
    assign out_vld  = full;
    assign out_data = data;

    // Load has priority over leave so a drain-and-refill keeps the slot full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_vld && in_rdy) begin
            full <= 1'b1;
            data <= in_data;
        end else if (leave) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/spinn_aer_if_cmd_demux.sv
// Ingress classifier: parity check, steer control keys to cpkt, others to opkt or drop; stats counters.
// Latency: two cycles from input acceptance to cpkt/opkt valid when the target register is free.
// Backpressure: S1 stalls while its target register is full and not draining (head-of-line blocking).
module spinn_aer_if_cmd_demux
    import spinn_aer_if_cmd_demux_pkg::*;
#(
    parameter logic [KEY_BITS-1:0] CTL_KEY  = 32'hFFFF_FE00,
    parameter logic [KEY_BITS-1:0] CTL_MASK = 32'hFFFF_FF00,
    parameter bit                  FWD_EN   = 1'b1,
    parameter int                  CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PKT_BITS-1:0] ipkt_data,
    input  logic                ipkt_vld,
    output logic                ipkt_rdy,
    output logic [PKT_BITS-1:0] cpkt_data,
    output logic                cpkt_vld,
    input  logic                cpkt_rdy,
    output logic [PKT_BITS-1:0] opkt_data,
    output logic                opkt_vld,
    input  logic                opkt_rdy,
    output logic [CNT_BITS-1:0] ctl_cnt,
    output logic [CNT_BITS-1:0] fwd_cnt,
    output logic [CNT_BITS-1:0] drp_cnt
);

    // Parity and control-key match; control requires good parity and a multicast type.
    function automatic pkt_class_t classify(input logic [PKT_BITS-1:0] pkt);
        pkt_class_t c;
        logic [KEY_BITS-1:0] key;
        key      = pkt[KEY_MSB:KEY_LSB];
        c.par_ok = odd_parity_ok(pkt);
        c.ctl    = c.par_ok
                && (pkt_type_e'(pkt[TYPE_MSB:TYPE_LSB]) == PKT_MC)
                && ((key & CTL_MASK) == (CTL_KEY & CTL_MASK));
        return c;
    endfunction

    logic [PKT_BITS-1:0] s1_data;
    logic                s1_vld;
    logic                s1_in_rdy;
    logic                s1_sel_rdy;
    logic                s1_drop;
    pkt_class_t          cls;

    logic                c_in_rdy;
    logic                o_in_rdy;
    logic                to_c;
    logic                to_o;

    logic [2:0]          ev;
    logic [CNT_BITS-1:0] cnt_arr [3];

    // Reset holds off the input even though the slot itself reads as empty.
    assign ipkt_rdy = s1_in_rdy && !rst;

    spinn_aer_if_pkt_reg #(.W(PKT_BITS)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (ipkt_data),
        .in_vld   (ipkt_vld),
        .in_rdy   (s1_in_rdy),
        .out_data (s1_data),
        .out_vld  (s1_vld),
        .out_rdy  (s1_sel_rdy),
        .drop     (s1_drop)
    );

    assign cls        = classify(s1_data);
    assign s1_drop    = !cls.par_ok || (!cls.ctl && !FWD_EN);
    assign s1_sel_rdy = cls.ctl ? c_in_rdy : o_in_rdy;
    assign to_c       = s1_vld && cls.ctl;
    assign to_o       = s1_vld && cls.par_ok && !cls.ctl && FWD_EN;

    spinn_aer_if_pkt_reg #(.W(PKT_BITS)) u_c (
        .clk      (clk),
        .rst      (rst),
        .in_data  (s1_data),
        .in_vld   (to_c),
        .in_rdy   (c_in_rdy),
        .out_data (cpkt_data),
        .out_vld  (cpkt_vld),
        .out_rdy  (cpkt_rdy),
        .drop     (1'b0)
    );

    spinn_aer_if_pkt_reg #(.W(PKT_BITS)) u_o (
        .clk      (clk),
        .rst      (rst),
        .in_data  (s1_data),
        .in_vld   (to_o),
        .in_rdy   (o_in_rdy),
        .out_data (opkt_data),
        .out_vld  (opkt_vld),
        .out_rdy  (opkt_rdy),
        .drop     (1'b0)
    );

    // Counting events are the S1 routing decisions, not the downstream handshakes.
    assign ev[0] = to_c && c_in_rdy;
    assign ev[1] = to_o && o_in_rdy;
    assign ev[2] = s1_vld && s1_drop;

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        logic [CNT_BITS-1:0] cnt_q;

        // Saturating event counter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (ev[i] && (cnt_q != {CNT_BITS{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt_arr[i] = cnt_q;
    end

    assign ctl_cnt = cnt_arr[0];
    assign fwd_cnt = cnt_arr[1];
    assign drp_cnt = cnt_arr[2];

endmodule

// File: tb/tb_spinn_aer_if_cmd_demux.sv
module tb_spinn_aer_if_cmd_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] ipkt_data;
    logic        ipkt_vld;
    logic        ipkt_vld0;
    logic        cpkt_rdy;
    logic        opkt_rdy;

    logic        ipkt_rdy, cpkt_vld, opkt_vld;
    logic [71:0] cpkt_data, opkt_data;
    logic [15:0] ctl_cnt, fwd_cnt, drp_cnt;

    logic        ipkt_rdy0, cpkt_vld0, opkt_vld0;
    logic [71:0] cpkt_data0, opkt_data0;
    logic [15:0] ctl_cnt0, fwd_cnt0, drp_cnt0;

    int checks   = 0;
    int failures = 0;

    logic [71:0] qc[$];
    logic [71:0] qo[$];
    int          mc, mf, md;
    int          cur_cat;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    spinn_aer_if_cmd_demux dut (
        .clk(clk), .rst(rst),
        .ipkt_data(ipkt_data), .ipkt_vld(ipkt_vld), .ipkt_rdy(ipkt_rdy),
        .cpkt_data(cpkt_data), .cpkt_vld(cpkt_vld), .cpkt_rdy(cpkt_rdy),
        .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(opkt_rdy),
        .ctl_cnt(ctl_cnt), .fwd_cnt(fwd_cnt), .drp_cnt(drp_cnt)
    );

    spinn_aer_if_cmd_demux #(.FWD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .ipkt_data(ipkt_data), .ipkt_vld(ipkt_vld0), .ipkt_rdy(ipkt_rdy0),
        .cpkt_data(cpkt_data0), .cpkt_vld(cpkt_vld0), .cpkt_rdy(cpkt_rdy),
        .opkt_data(opkt_data0), .opkt_vld(opkt_vld0), .opkt_rdy(opkt_rdy),
        .ctl_cnt(ctl_cnt0), .fwd_cnt(fwd_cnt0), .drp_cnt(drp_cnt0)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Build a packet with correct odd parity, optionally inverted.
    function automatic logic [71:0] mk(input logic lng, input logic [1:0] typ,
                                       input logic [31:0] key, input logic [31:0] pl,
                                       input logic bad);
        logic [71:0] p;
        p = {pl, key, typ, 4'b0000, lng, 1'b0};
        if (lng) p[0] = ~(^p);
        else     p[0] = ~(^p[39:0]);
        if (bad) p[0] = ~p[0];
        return p;
    endfunction

    task automatic send(input logic [71:0] p);
        logic acc;
        acc       = 1'b0;
        ipkt_data = p;
        ipkt_vld  = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = ipkt_rdy;
            @(posedge clk);
            #2;
        end
        ipkt_vld = 1'b0;
        if (!acc) chk("send_timeout", 72'd0, 72'd1);
    endtask

    // Scoreboard: record accepted packets, compare each downstream transfer in order.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (cpkt_vld && cpkt_rdy) begin
                if (qc.size() > 0) chk("sb_cpkt", cpkt_data, qc.pop_front());
                else               chk("sb_cpkt_extra", cpkt_data, 72'hx);
            end
            if (opkt_vld && opkt_rdy) begin
                if (qo.size() > 0) chk("sb_opkt", opkt_data, qo.pop_front());
                else               chk("sb_opkt_extra", opkt_data, 72'hx);
            end
            if (ipkt_vld && ipkt_rdy) begin
                case (cur_cat)
                    0:       begin qc.push_back(ipkt_data); mc++; end
                    1:       begin qo.push_back(ipkt_data); mf++; end
                    default: md++;
                endcase
            end
        end
    end

    initial begin
        logic [71:0] p2, p3, p4, p5a, p5b, p5c, np;
        logic        fire;
        int          r;

        p2  = {32'h0000_0000, 32'hFFFF_FE01, 8'h01};
        p3  = {32'hDEAD_BEEF, 32'h1234_5600, 8'h03};
        p4  = {32'h0000_0000, 32'hFFFF_FE01, 8'h00};
        p5a = mk(1'b0, 2'b00, 32'hFFFF_FE10, 32'h0000_0001, 1'b0);
        p5b = mk(1'b1, 2'b00, 32'hFFFF_FE11, 32'h0000_0002, 1'b0);
        p5c = mk(1'b0, 2'b00, 32'hFFFF_FE12, 32'h0000_0003, 1'b0);

        // Reset with a pending input.
        rst = 1'b1; ipkt_vld = 1'b1; ipkt_vld0 = 1'b0; ipkt_data = '0;
        cpkt_rdy = 1'b1; opkt_rdy = 1'b1;
        mc = 0; mf = 0; md = 0; cur_cat = 0;
        repeat (3) step();
        chk("rst_ipkt_rdy", {71'd0, ipkt_rdy}, 72'd0);
        chk("rst_cpkt_vld", {71'd0, cpkt_vld}, 72'd0);
        chk("rst_opkt_vld", {71'd0, opkt_vld}, 72'd0);
        chk("rst_cpkt_data", cpkt_data, 72'd0);
        chk("rst_counters", {24'd0, ctl_cnt, fwd_cnt, drp_cnt}, 72'd0);
        ipkt_vld = 1'b0;
        rst = 1'b0;
        step();
        chk("rel_ipkt_rdy", {71'd0, ipkt_rdy}, 72'd1);

        // Short control packet.
        ipkt_data = p2; ipkt_vld = 1'b1;
        step();
        ipkt_vld = 1'b0;
        chk("ctl_lat1_vld", {71'd0, cpkt_vld}, 72'd0);
        step();
        chk("ctl_vld", {71'd0, cpkt_vld}, 72'd1);
        chk("ctl_data", cpkt_data, p2);
        chk("ctl_cnt1", {56'd0, ctl_cnt}, 72'd1);
        step();
        chk("ctl_drained", {71'd0, cpkt_vld}, 72'd0);

        // Long forward packet.
        ipkt_data = p3; ipkt_vld = 1'b1;
        step();
        ipkt_vld = 1'b0;
        step();
        chk("fwd_vld", {71'd0, opkt_vld}, 72'd1);
        chk("fwd_data", opkt_data, p3);
        chk("fwd_cnt1", {56'd0, fwd_cnt}, 72'd1);
        chk("fwd_no_cpkt", {71'd0, cpkt_vld}, 72'd0);
        step();

        // Same packet with forwarding disabled.
        ipkt_vld0 = 1'b1;
        step();
        ipkt_vld0 = 1'b0;
        step();
        chk("nofwd_opkt_vld", {71'd0, opkt_vld0}, 72'd0);
        chk("nofwd_drp_cnt", {56'd0, drp_cnt0}, 72'd1);
        chk("nofwd_fwd_cnt", {56'd0, fwd_cnt0}, 72'd0);

        // Control packet with bad parity.
        ipkt_data = p4; ipkt_vld = 1'b1;
        step();
        ipkt_vld = 1'b0;
        step();
        chk("bad_cpkt_vld", {71'd0, cpkt_vld}, 72'd0);
        chk("bad_drp_cnt", {56'd0, drp_cnt}, 72'd1);
        chk("bad_ctl_cnt", {56'd0, ctl_cnt}, 72'd1);

        // Backpressure on the control port.
        cpkt_rdy = 1'b0;
        ipkt_data = p5a; ipkt_vld = 1'b1;
        step();
        ipkt_data = p5b;
        step();
        ipkt_data = p5c;
        chk("bp_rdy_low", {71'd0, ipkt_rdy}, 72'd0);
        step();
        chk("bp_rdy_still_low", {71'd0, ipkt_rdy}, 72'd0);
        chk("bp_hold_p1", cpkt_data, p5a);
        cpkt_rdy = 1'b1;
        #1;
        chk("bp_rdy_refill", {71'd0, ipkt_rdy}, 72'd1);
        step();
        ipkt_vld = 1'b0;
        chk("bp_p2", cpkt_data, p5b);
        chk("bp_p2_vld", {71'd0, cpkt_vld}, 72'd1);
        step();
        chk("bp_p3", cpkt_data, p5c);
        step();
        chk("bp_empty", {71'd0, cpkt_vld}, 72'd0);
        chk("bp_ctl_cnt", {56'd0, ctl_cnt}, 72'd4);

        // Random mixed traffic with a reset in the middle.
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc == 400) begin
                rst = 1'b1; ipkt_vld = 1'b0;
                qc.delete(); qo.delete();
                mc = 0; mf = 0; md = 0;
                step(); step();
                rst = 1'b0;
            end
            @(negedge clk);
            fire = ipkt_vld && ipkt_rdy;
            @(posedge clk);
            #2;
            if (fire || !ipkt_vld) begin
                if ($urandom_range(0, 3) != 0) begin
                    r = $urandom_range(0, 2);
                    case (r)
                        0: np = mk(1'($urandom_range(0, 1)), 2'b00,
                                   {24'hFFFF_FE, 8'($urandom)}, $urandom, 1'b0);
                        1: np = ($urandom_range(0, 1) != 0)
                              ? mk(1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
                                   {24'hFFFF_FE, 8'($urandom)}, $urandom, 1'b0)
                              : mk(1'($urandom_range(0, 1)), 2'b00,
                                   {24'h1234_56, 8'($urandom)}, $urandom, 1'b0);
                        default: np = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                         $urandom, $urandom, 1'b1);
                    endcase
                    cur_cat   = r;
                    ipkt_data = np;
                    ipkt_vld  = 1'b1;
                end else begin
                    ipkt_vld = 1'b0;
                end
            end
            cpkt_rdy = 1'($urandom_range(0, 1));
            opkt_rdy = 1'($urandom_range(0, 1));
        end
        // The last pending packet is withdrawn only after its acceptance was sampled.
        @(negedge clk);
        @(posedge clk);
        #2;
        ipkt_vld = 1'b0;
        cpkt_rdy = 1'b1;
        opkt_rdy = 1'b1;
        repeat (10) step();
        chk("sb_c_empty", 72'(qc.size()), 72'd0);
        chk("sb_o_empty", 72'(qo.size()), 72'd0);
        chk("rnd_ctl_cnt", {56'd0, ctl_cnt}, 72'(mc));
        chk("rnd_fwd_cnt", {56'd0, fwd_cnt}, 72'(mf));
        chk("rnd_drp_cnt", {56'd0, drp_cnt}, 72'(md));
        mon_en = 1'b0;

        // Saturation with preloaded counters.
        force dut.g_cnt[0].cnt_q = 16'hFFFE;
        #1;
        release dut.g_cnt[0].cnt_q;
        send(p2);
        repeat (3) step();
        chk("sat_ctl_ffff", {56'd0, ctl_cnt}, 72'h0FFFF);
        send(p2);
        repeat (3) step();
        chk("sat_ctl_hold", {56'd0, ctl_cnt}, 72'h0FFFF);
        force dut.g_cnt[2].cnt_q = 16'hFFFF;
        #1;
        release dut.g_cnt[2].cnt_q;
        send(p4);
        repeat (3) step();
        chk("sat_drp_hold", {56'd0, drp_cnt}, 72'h0FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
